// File: rtl/match_scoreboard_if.sv
// Point/start request inputs and score/status outputs of the match scoreboard.
// The controller takes the slave side; the stimulus or upstream logic takes the master side.
interface match_scoreboard_if;
   logic       point_p1;
   logic       point_p2;
   logic       start_btn;
   logic [2:0] score1;
   logic [2:0] score2;
   logic       in_play;
   logic       game_over;
   logic [1:0] winner;
   logic       point_strobe;

   modport master (
      output point_p1, point_p2, start_btn,
      input  score1, score2, in_play, game_over, winner, point_strobe
   );

   modport slave (
      input  point_p1, point_p2, start_btn,
      output score1, score2, in_play, game_over, winner, point_strobe
   );
endinterface

// File: rtl/match_scoreboard.sv
// Two-player match controller: synchronises point/start requests, runs IDLE/PLAY/OVER,
// and holds the scores, winner and a shared lockout/hold down-counter.
module match_scoreboard #(
   parameter int WIN_SCORE   = 5,
   parameter int LOCK_CYCLES = 100_000_000,
   parameter int HOLD_CYCLES = 300_000_000,
   parameter int CNT_W       = 29
) (
   input  logic              basys3_clk,
   input  logic              reset_n,
   match_scoreboard_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [2:0]       WIN       = 3'(WIN_SCORE);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   // Bit 0 = point_p1, bit 1 = point_p2, bit 2 = start_btn.
   logic [2:0] raw, sync1, sync2, sync3, edges;

   state_t           state, state_n;
   logic [2:0]       score1_q, score1_n, score2_q, score2_n;
   logic [1:0]       winner_q, winner_n;
   logic             strobe_q, strobe_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   assign raw   = {bus.start_btn, bus.point_p2, bus.point_p1};
   assign edges = sync2 & ~sync3;

   // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge basys3_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // NOTE: every next-value signal gets a default before the case, so no latch is inferred.
   always_comb begin
      state_n  = state;
      score1_n = score1_q;
      score2_n = score2_q;
      winner_n = winner_q;
      strobe_n = 1'b0;
      cnt_n    = (cnt != '0) ? cnt - CNT_W'(1) : cnt;

      case (state)
         IDLE: begin
            score1_n = '0;
            score2_n = '0;
            winner_n = 2'b00;
            if (edges[2]) begin
               state_n = PLAY;
               cnt_n   = '0;
            end
         end
         PLAY: begin
            // Simultaneous edges are a conflict and award nothing.
            if (cnt == '0 && (edges[0] ^ edges[1])) begin
               strobe_n = 1'b1;
               cnt_n    = LOCK_LOAD;
               if (edges[0]) begin
                  score1_n = score1_q + 3'd1;
                  if (score1_n == WIN) begin
                     state_n  = OVER;
                     winner_n = 2'b01;
                     cnt_n    = HOLD_LOAD;
                  end
               end else begin
                  score2_n = score2_q + 3'd1;
                  if (score2_n == WIN) begin
                     state_n  = OVER;
                     winner_n = 2'b10;
                     cnt_n    = HOLD_LOAD;
                  end
               end
            end
         end
         OVER: begin
            if (edges[2] && cnt == '0) begin
               state_n  = PLAY;
               score1_n = '0;
               score2_n = '0;
               winner_n = 2'b00;
            end
         end
         default: begin
            state_n  = IDLE;
            score1_n = '0;
            score2_n = '0;
            winner_n = 2'b00;
            cnt_n    = '0;
         end
      endcase
   end

   always_ff @(posedge basys3_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         score1_q <= '0;
         score2_q <= '0;
         winner_q <= 2'b00;
         strobe_q <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_n;
         score1_q <= score1_n;
         score2_q <= score2_n;
         winner_q <= winner_n;
         strobe_q <= strobe_n;
         cnt      <= cnt_n;
      end
   end

   assign bus.score1       = score1_q;
   assign bus.score2       = score2_q;
   assign bus.winner       = winner_q;
   assign bus.point_strobe = strobe_q;
   assign bus.in_play      = (state == PLAY);
   assign bus.game_over    = (state == OVER);

endmodule

// File: tb/tb_match_scoreboard.sv
// Scoreboard bench: a timestamp-based match model queues every expected output change,
// and a monitor pops and compares whenever the DUT outputs change.
module tb_match_scoreboard;

   localparam int WIN  = 3;
   localparam int LOCK = 4;
   localparam int HOLD = 8;

   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_OVER = 2;

   typedef struct packed {
      logic [2:0] s1;
      logic [2:0] s2;
      logic       in_play;
      logic       game_over;
      logic [1:0] winner;
      logic       strobe;
   } snap_t;

   typedef struct {
      snap_t v;
      int    stamp;
   } exp_t;

   localparam snap_t RST_SNAP = '0;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   match_scoreboard_if bus ();

   match_scoreboard #(
      .WIN_SCORE  (WIN),
      .LOCK_CYCLES(LOCK),
      .HOLD_CYCLES(HOLD),
      .CNT_W      (29)
   ) dut (
      .basys3_clk(clk),
      .reset_n   (reset_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   // Cycle index: a posedge and the negedge after it share one stamp, as does a
   // reset asserted in the low phase just before that posedge.
   function automatic int stamp();
      return int'(($time + 9) / 10);
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.s1        = bus.score1;
      s.s2        = bus.score2;
      s.in_play   = bus.in_play;
      s.game_over = bus.game_over;
      s.winner    = bus.winner;
      s.strobe    = bus.point_strobe;
      return s;
   endfunction

   task automatic check(string name, snap_t got, snap_t want, int got_t, int want_t);
      vectors++;
      if (got !== want || got_t != want_t) begin
         miscompares++;
         $display("FAIL %s: got t=%0d s=%0d:%0d play=%0b over=%0b win=%0d strobe=%0b, want t=%0d s=%0d:%0d play=%0b over=%0b win=%0d strobe=%0b",
                  name, got_t, got.s1, got.s2, got.in_play, got.game_over, got.winner, got.strobe,
                  want_t, want.s1, want.s2, want.in_play, want.game_over, want.winner, want.strobe);
      end
   endtask

   // Reference model: an input edge is acted on two clocks after it is first sampled;
   // lockout and hold are tracked as the cycle from which input is accepted again.
   initial begin : model
      int    mode, s1, s2, win, lock_end, hold_end, now;
      bit    strobe, e1, e2, es;
      bit [2:0] h1, h2, hs;
      snap_t last, cur;
      mode = M_IDLE; s1 = 0; s2 = 0; win = 0; strobe = 0;
      lock_end = 0; hold_end = 0; h1 = '0; h2 = '0; hs = '0;
      last = RST_SNAP;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            mode = M_IDLE; s1 = 0; s2 = 0; win = 0; strobe = 0;
            lock_end = 0; hold_end = 0; h1 = '0; h2 = '0; hs = '0;
         end else begin
            now    = stamp();
            e1     = h1[1] & ~h1[2];
            e2     = h2[1] & ~h2[2];
            es     = hs[1] & ~hs[2];
            strobe = 0;
            case (mode)
               M_IDLE: if (es) begin
                  mode     = M_PLAY;
                  lock_end = now;
               end
               M_PLAY: if (now >= lock_end && (e1 != e2)) begin
                  strobe   = 1;
                  lock_end = now + LOCK;
                  if (e1) s1++; else s2++;
                  if (s1 == WIN || s2 == WIN) begin
                     mode     = M_OVER;
                     win      = (s1 == WIN) ? 1 : 2;
                     hold_end = now + HOLD;
                  end
               end
               M_OVER: if (es && now >= hold_end) begin
                  mode     = M_PLAY;
                  s1       = 0;
                  s2       = 0;
                  win      = 0;
                  lock_end = now;
               end
               default: mode = M_IDLE;
            endcase
            h1 = {h1[1:0], bus.point_p1};
            h2 = {h2[1:0], bus.point_p2};
            hs = {hs[1:0], bus.start_btn};
         end
         cur.s1        = 3'(s1);
         cur.s2        = 3'(s2);
         cur.in_play   = (mode == M_PLAY);
         cur.game_over = (mode == M_OVER);
         cur.winner    = 2'(win);
         cur.strobe    = strobe;
         if (cur != last) begin
            exp_q.push_back('{cur, stamp()});
            last = cur;
         end
      end
   end

   initial begin : monitor
      snap_t prev, cur;
      exp_t  e;
      prev = RST_SNAP;
      forever begin
         @(negedge clk);
         cur = dut_snap();
         if (cur != prev) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_change: t=%0d s=%0d:%0d play=%0b over=%0b win=%0d strobe=%0b, no change expected",
                        stamp(), cur.s1, cur.s2, cur.in_play, cur.game_over, cur.winner, cur.strobe);
            end else begin
               e = exp_q.pop_front();
               check("output_event", cur, e.v, stamp(), e.stamp);
            end
            prev = cur;
         end
      end
   end

   task automatic cycles(int k);
      repeat (k) @(negedge clk);
   endtask

   // which: 0 = point_p1, 1 = point_p2, 2 = start_btn
   task automatic pulse(int which, int len);
      case (which)
         0:       bus.point_p1  = 1'b1;
         1:       bus.point_p2  = 1'b1;
         default: bus.start_btn = 1'b1;
      endcase
      cycles(len);
      case (which)
         0:       bus.point_p1  = 1'b0;
         1:       bus.point_p2  = 1'b0;
         default: bus.start_btn = 1'b0;
      endcase
   endtask

   task automatic reset_mid(string name);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check(name, dut_snap(), RST_SNAP, stamp(), stamp());
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin : stimulus
      bus.point_p1  = 1'b0;
      bus.point_p2  = 1'b0;
      bus.start_btn = 1'b0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      check("reset_state", dut_snap(), RST_SNAP, stamp(), stamp());
      reset_n = 1'b1;

      // Start, then three p1 points to win.
      cycles(2);
      pulse(2, 1);
      cycles(5);
      for (int i = 0; i < 3; i++) begin
         pulse(0, 1);
         if (i < 2) cycles(9);
      end

      // Early start in OVER is ignored; a later one restarts.
      cycles(2);
      pulse(2, 1);
      cycles(10);
      pulse(2, 1);
      cycles(5);

      // p2 inside the p1 lockout is dropped; a later p2 counts.
      pulse(0, 1);
      cycles(1);
      pulse(1, 1);
      cycles(5);
      pulse(1, 1);
      cycles(6);

      // Reach 2:1 with lockout running, reset with p1 held across release.
      pulse(0, 1);
      cycles(2);
      bus.point_p1 = 1'b1;
      reset_mid("reset_mid_play");
      cycles(4);
      pulse(2, 1);
      cycles(10);
      bus.point_p1 = 1'b0;
      cycles(3);
      pulse(0, 1);
      cycles(6);

      // Simultaneous rise is a conflict; p2 right after is awarded.
      bus.point_p1 = 1'b1;
      bus.point_p2 = 1'b1;
      cycles(1);
      bus.point_p1 = 1'b0;
      bus.point_p2 = 1'b0;
      cycles(1);
      pulse(1, 1);
      cycles(6);

      // Randomised play with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset_mid("reset_random");
         end else begin
            @(negedge clk);
            bus.point_p1  = ($urandom_range(0, 99) < 25);
            bus.point_p2  = ($urandom_range(0, 99) < 25);
            bus.start_btn = ($urandom_range(0, 99) < 10);
         end
      end

      bus.point_p1  = 1'b0;
      bus.point_p2  = 1'b0;
      bus.start_btn = 1'b0;
      cycles(12);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_events: got %0d expected changes never seen, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
